main_memory_resp: RTL and testbench

- Main-memory responder that sits on the far side of the cache's miss/write-back interface.
- Accepts a line-fill request (load) or a write-back request (store) from the cache, with a 32-bit byte address.
- After a fixed access latency, streams one 16-word line out (fill) or absorbs one 16-word line (write-back).
- Signals end of transfer with a level "complete" handshake. Backing store is an internal word array.

---
 rtl/main_memory_resp.sv | 113 +++++++++++
 tb/tb_main_memory_resp.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/main_memory_resp.sv
// Main-memory responder for cache line fills and write-backs.
// Fixed access latency, then a 16-beat burst, then a level complete handshake.
module main_memory_resp #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4,
  parameter int BURST_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  store,
  input  logic [31:0]           addr_in,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  beat_valid,
  output logic [BURST_LOG2-1:0] beat_cnt,
  output logic                  busy,
  output logic                  complete
);

  localparam int LINE_W = DEPTH_LOG2 - BURST_LOG2;
  localparam int LW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [LW-1:0] LAT_LAST =
    LW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [BURST_LOG2-1:0] FIRST_BEAT = '0;
  localparam logic [BURST_LOG2-1:0] LAST_BEAT  = '1;

  typedef enum logic [2:0] {
    IDLE, WAIT, LOAD_BURST, STORE_BURST, DONE
  } state_t;

  state_t                  state;
  logic                    is_store;
  logic [LINE_W-1:0]       line;
  logic [LW-1:0]           lat_cnt;
  logic [31:0]             mem [2**DEPTH_LOG2];
  logic [LINE_W-1:0]       req_line;
  logic [BURST_LOG2-1:0]   next_beat;
  logic                    unused;

  assign req_line  = addr_in[DEPTH_LOG2+1:BURST_LOG2+2];
  assign next_beat = beat_cnt + 1'b1;
  assign unused    = ^{addr_in[31:DEPTH_LOG2+2],
                       addr_in[BURST_LOG2+1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      is_store   <= 1'b0;
      line       <= '0;
      lat_cnt    <= '0;
      load_data  <= '0;
      beat_valid <= 1'b0;
      beat_cnt   <= '0;
      busy       <= 1'b0;
      complete   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load || store) begin
            // store wins so the dirty line is written before refill
            is_store <= store;
            line     <= req_line;
            busy     <= 1'b1;
            lat_cnt  <= '0;
            if (LATENCY == 0) begin
              state      <= store ? STORE_BURST : LOAD_BURST;
              beat_valid <= 1'b1;
              beat_cnt   <= FIRST_BEAT;
              load_data  <= mem[{req_line, FIRST_BEAT}];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state      <= is_store ? STORE_BURST : LOAD_BURST;
            beat_valid <= 1'b1;
            beat_cnt   <= FIRST_BEAT;
            load_data  <= mem[{line, FIRST_BEAT}];
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        LOAD_BURST, STORE_BURST: begin
          beat_cnt  <= next_beat;
          load_data <= mem[{line, next_beat}];
          if (beat_cnt == LAST_BEAT) begin
            state      <= DONE;
            beat_valid <= 1'b0;
            complete   <= 1'b1;
          end
        end
        DONE: begin
          if (!load && !store) begin
            state    <= IDLE;
            busy     <= 1'b0;
            complete <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // array is never reset; beats written before an abort stay put
  always_ff @(posedge clk) begin
    if (state == STORE_BURST)
      mem[{line, beat_cnt}] <= store_data;
  end

endmodule

// File: tb/tb_main_memory_resp.sv
// Directed bench for main_memory_resp.
// Two instances: default latency 4 and latency 0.
module tb_main_memory_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_ld [2];
  logic        req_st [2];
  logic [31:0] req_ad [2];
  logic [31:0] sd     [2];
  logic [31:0] o_data [2];
  logic        bv     [2];
  logic [3:0]  bc     [2];
  logic        bz     [2];
  logic        cp     [2];
  logic [31:0] pat;
  int          checks = 0;
  int          errors = 0;
  bit          found;

  always #5 clk = ~clk;

  always_comb begin
    sd[0] = pat + 32'(bc[0]);
    sd[1] = pat + 32'(bc[1]);
  end

  main_memory_resp #(.LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .load(req_ld[0]), .store(req_st[0]),
    .addr_in(req_ad[0]), .store_data(sd[0]), .load_data(o_data[0]),
    .beat_valid(bv[0]), .beat_cnt(bc[0]), .busy(bz[0]),
    .complete(cp[0])
  );

  main_memory_resp #(.LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .load(req_ld[1]), .store(req_st[1]),
    .addr_in(req_ad[1]), .store_data(sd[1]), .load_data(o_data[1]),
    .beat_valid(bv[1]), .beat_cnt(bc[1]), .busy(bz[1]),
    .complete(cp[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int sel);
    chk({tag, "_data"}, o_data[sel], 32'h0);
    chk({tag, "_valid"}, 32'(bv[sel]), 32'h0);
    chk({tag, "_cnt"}, 32'(bc[sel]), 32'h0);
    chk({tag, "_busy"}, 32'(bz[sel]), 32'h0);
    chk({tag, "_complete"}, 32'(cp[sel]), 32'h0);
  endtask

  // one full request; beats below split expect p+k, others alt+k
  task automatic xfer(input int sel, input logic st, input logic ldv,
                      input logic [31:0] a, input logic [31:0] p,
                      input logic [31:0] alt, input int split,
                      input int lat, input int hold,
                      input string tag);
    @(negedge clk);
    req_ld[sel] = ldv;
    req_st[sel] = st;
    req_ad[sel] = a;
    pat = p;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk({tag, "_wait_valid"}, 32'(bv[sel]), 32'h0);
      chk({tag, "_wait_busy"}, 32'(bz[sel]), 32'h1);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk({tag, "_beat_valid"}, 32'(bv[sel]), 32'h1);
      chk({tag, "_beat_cnt"}, 32'(bc[sel]), 32'(k));
      if (!st)
        chk({tag, "_data"}, o_data[sel],
            (k < split) ? p + 32'(k) : alt + 32'(k));
    end
    @(negedge clk);
    chk({tag, "_done_complete"}, 32'(cp[sel]), 32'h1);
    chk({tag, "_done_valid"}, 32'(bv[sel]), 32'h0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_complete"}, 32'(cp[sel]), 32'h1);
      chk({tag, "_hold_busy"}, 32'(bz[sel]), 32'h1);
    end
    req_ld[sel] = 1'b0;
    req_st[sel] = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_complete"}, 32'(cp[sel]), 32'h0);
    chk({tag, "_idle_busy"}, 32'(bz[sel]), 32'h0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_ld[s] = 1'b0;
      req_st[s] = 1'b0;
      req_ad[s] = '0;
    end
    pat = '0;
    #12;
    chk_idle("reset0", 0);
    chk_idle("reset1", 1);
    @(negedge clk);
    rst = 1'b0;

    // write-back then fill of words 0x50..0x5F
    xfer(0, 1, 0, 32'h0000_0140, 32'hA000_0000, 32'h0, 16, 4, 0, "st140");
    xfer(0, 0, 1, 32'h0000_0140, 32'hA000_0000, 32'h0, 16, 4, 2, "ld140");

    // both requests high: store first, then refill shows it
    xfer(0, 1, 1, 32'h0000_1000, 32'hE000_0000, 32'h0, 16, 4, 3, "both");
    xfer(0, 0, 1, 32'h0000_1000, 32'hE000_0000, 32'h0, 16, 4, 0, "ldboth");

    // address wrap modulo 4096 words
    xfer(0, 1, 0, 32'h0000_4040, 32'hD000_0000, 32'h0, 16, 4, 0, "stwrap");
    xfer(0, 0, 1, 32'h0000_0040, 32'hD000_0000, 32'h0, 16, 4, 0, "ldwrap");

    // reset during beat 7 of a write-back
    xfer(0, 1, 0, 32'h0000_0800, 32'hB000_0000, 32'h0, 16, 4, 0, "stold");
    @(negedge clk);
    req_st[0] = 1'b1;
    req_ad[0] = 32'h0000_0800;
    pat = 32'hC000_0000;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bv[0] && bc[0] == 4'd7) found = 1'b1;
    end
    chk("rst_reach_beat7", 32'(found), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk_idle("midrst", 0);
    req_st[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    xfer(0, 0, 1, 32'h0000_0800, 32'hC000_0000, 32'hB000_0000, 7, 4, 0,
         "ldsplit");

    // zero latency, back-to-back loads
    xfer(1, 1, 0, 32'h0000_2000, 32'hF000_0000, 32'h0, 16, 0, 0, "z_st");
    xfer(1, 0, 1, 32'h0000_2000, 32'hF000_0000, 32'h0, 16, 0, 0, "z_ld1");
    xfer(1, 0, 1, 32'h0000_2000, 32'hF000_0000, 32'h0, 16, 0, 0, "z_ld2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
